// File: rtl/chimera_cluster_pwr_seq.sv
// Per-cluster power sequencer: orders clock enable, cluster reset and AXI isolation
// for each cluster from a software power request, one independent Moore FSM per cluster.
module chimera_cluster_pwr_seq #(
   parameter int NumClusters     = 5,
   parameter bit IsolateClusters = 1'b1,
   parameter int RstCycles       = 8,
   parameter int AckTimeout      = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumClusters-1:0] pwr_req_i,
   input  logic [NumClusters-1:0] isolate_ack_i,
   input  logic [NumClusters-1:0] err_clr_i,
   output logic [NumClusters-1:0] isolate_o,
   output logic [NumClusters-1:0] clk_en_o,
   output logic [NumClusters-1:0] cluster_rst_o,
   output logic [NumClusters-1:0] pwr_on_o,
   output logic [NumClusters-1:0] busy_o,
   output logic [NumClusters-1:0] err_o
);

   localparam int AckW = (AckTimeout > 0) ? $clog2(AckTimeout + 1) : 1;
   localparam int CntW = (AckW > 8) ? AckW : 8;
   localparam logic [CntW-1:0] RstLast = CntW'(RstCycles - 1);
   localparam logic [CntW-1:0] AckLast = CntW'((AckTimeout > 0) ? AckTimeout - 1 : 0);
   localparam bit UseTimeout = (AckTimeout > 0);

   typedef enum logic [2:0] {
      Off, ClkUp, RstRel, Deiso, On, Iso, RstDn, ClkDn
   } stateT;

   for (genvar c = 0; c < NumClusters; c++) begin : gCluster
      stateT           state, stateNext;
      logic [CntW-1:0] cnt, cntNext;
      logic            err, errSet;
      logic            ackTo;
      logic            iso, clkEn, clRst;

      assign ackTo = UseTimeout && (cnt == AckLast);

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            state <= Off;
            cnt   <= '0;
            err   <= 1'b0;
         end else begin
            state <= stateNext;
            cnt   <= cntNext;
            // A timeout on the same edge as a clear keeps the error visible.
            if (errSet) begin
               err <= 1'b1;
            end else if (err_clr_i[c]) begin
               err <= 1'b0;
            end
         end
      end

      always_comb begin
         stateNext = state;
         errSet    = 1'b0;
         case (state)
            Off:    if (pwr_req_i[c]) stateNext = ClkUp;
            ClkUp:  if (cnt == RstLast) stateNext = RstRel;
            RstRel: stateNext = IsolateClusters ? Deiso : On;
            Deiso: begin
               if (!isolate_ack_i[c]) begin
                  stateNext = On;
               end else if (ackTo) begin
                  errSet    = 1'b1;
                  stateNext = On;
               end
            end
            On:     if (!pwr_req_i[c]) stateNext = IsolateClusters ? Iso : RstDn;
            Iso: begin
               if (isolate_ack_i[c]) begin
                  stateNext = RstDn;
               end else if (ackTo) begin
                  errSet    = 1'b1;
                  stateNext = RstDn;
               end
            end
            RstDn:  if (cnt == RstLast) stateNext = ClkDn;
            ClkDn:  stateNext = Off;
            default: stateNext = Off;
         endcase

         if (stateNext != state) begin
            cntNext = '0;
         end else if (state inside {ClkUp, Deiso, Iso, RstDn}) begin
            cntNext = cnt + 1'b1;
         end else begin
            cntNext = cnt;
         end
      end

      always_comb begin
         iso   = 1'b1;
         clkEn = 1'b1;
         clRst = 1'b0;
         case (state)
            Off:    begin clkEn = 1'b0; clRst = 1'b1; end
            ClkUp:  clRst = 1'b1;
            RstRel: ;
            Deiso:  iso = 1'b0;
            On:     iso = 1'b0;
            Iso:    ;
            RstDn:  clRst = 1'b1;
            ClkDn:  begin clkEn = 1'b0; clRst = 1'b1; end
            default: begin clkEn = 1'b0; clRst = 1'b1; end
         endcase
      end

      assign isolate_o[c]     = IsolateClusters && iso;
      assign clk_en_o[c]      = clkEn;
      assign cluster_rst_o[c] = clRst;
      assign pwr_on_o[c]      = (state == On);
      assign busy_o[c]        = !(state inside {Off, On});
      assign err_o[c]         = err;
   end

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Bench for chimera_cluster_pwr_seq: sequence-timeline model checked every cycle,
// plus hand-computed edge expectations for up/down latency, timeouts and async reset.
module tb_chimera_cluster_pwr_seq;

   localparam int R  = 4;
   localparam int T  = 16;
   localparam int NA = 5;
   localparam int NB = 2;

   localparam int PhOff  = 0;
   localparam int PhUp   = 1;
   localparam int PhOn   = 2;
   localparam int PhDown = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [NA-1:0] reqA = '0, ackA = '0, clrA = '0;
   logic [NA-1:0] isoA, clkEnA, cRstA, onA, busyA, errA;
   logic [NB-1:0] reqB = '0, ackB = '0, clrB = '0;
   logic [NB-1:0] isoB, clkEnB, cRstB, onB, busyB, errB;

   int errors = 0;
   int checks = 0;

   chimera_cluster_pwr_seq #(
      .NumClusters(NA), .IsolateClusters(1'b1), .RstCycles(R), .AckTimeout(T)
   ) dutA (
      .clk_i(clk), .rst_i(rst), .pwr_req_i(reqA), .isolate_ack_i(ackA), .err_clr_i(clrA),
      .isolate_o(isoA), .clk_en_o(clkEnA), .cluster_rst_o(cRstA), .pwr_on_o(onA),
      .busy_o(busyA), .err_o(errA)
   );

   chimera_cluster_pwr_seq #(
      .NumClusters(NB), .IsolateClusters(1'b0), .RstCycles(R), .AckTimeout(T)
   ) dutB (
      .clk_i(clk), .rst_i(rst), .pwr_req_i(reqB), .isolate_ack_i(ackB), .err_clr_i(clrB),
      .isolate_o(isoB), .clk_en_o(clkEnB), .cluster_rst_o(cRstB), .pwr_on_o(onB),
      .busy_o(busyB), .err_o(errB)
   );

   always #5 clk = ~clk;

   // Model: idle phases plus a step index t through the up or down sequence.
   // Up: t<R clocks in reset, t==R reset released, t==R+1 waiting for de-isolation.
   // Down: t==0 waiting for isolation, 1..R reset held, R+1 clocks stopped.
   typedef struct {
      int phase;
      int t;
      int w;
      bit err;
   } mdlT;

   mdlT mA[NA];
   mdlT mB[NB];

   function automatic mdlT step(mdlT m, bit isoEn, bit req, bit ack, bit clr);
      mdlT n;
      bit timeout;
      n = m;
      timeout = (T != 0) && (m.w == T - 1);
      if (clr) n.err = 1'b0;
      case (m.phase)
         PhOff: if (req) begin n.phase = PhUp; n.t = 0; end
         PhUp: begin
            if (m.t < R) n.t = m.t + 1;
            else if (m.t == R) begin
               if (isoEn) begin n.t = R + 1; n.w = 0; end
               else n.phase = PhOn;
            end
            else if (!ack) n.phase = PhOn;
            else if (timeout) begin n.err = 1'b1; n.phase = PhOn; end
            else n.w = m.w + 1;
         end
         PhOn: if (!req) begin n.phase = PhDown; n.t = isoEn ? 0 : 1; n.w = 0; end
         default: begin
            if (m.t == 0) begin
               if (ack) n.t = 1;
               else if (timeout) begin n.err = 1'b1; n.t = 1; end
               else n.w = m.w + 1;
            end
            else if (m.t <= R) n.t = m.t + 1;
            else n.phase = PhOff;
         end
      endcase
      return n;
   endfunction

   // {isolate, clk_en, cluster_rst, pwr_on, busy, err}
   function automatic logic [5:0] outs(mdlT m, bit isoEn);
      logic iso, ck, rs;
      iso = isoEn;
      ck  = 1'b1;
      rs  = 1'b0;
      case (m.phase)
         PhOff: begin ck = 1'b0; rs = 1'b1; end
         PhUp:  begin
            if (m.t < R) rs = 1'b1;
            else if (m.t > R) iso = 1'b0;
         end
         PhOn:  iso = 1'b0;
         default: begin
            if (m.t >= 1 && m.t <= R) rs = 1'b1;
            else if (m.t > R) begin ck = 1'b0; rs = 1'b1; end
         end
      endcase
      return {iso, ck, rs, m.phase == PhOn, (m.phase == PhUp) || (m.phase == PhDown), m.err};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NA; i++) mA[i] <= '{PhOff, 0, 0, 1'b0};
         for (int i = 0; i < NB; i++) mB[i] <= '{PhOff, 0, 0, 1'b0};
      end else begin
         for (int i = 0; i < NA; i++) mA[i] <= step(mA[i], 1'b1, reqA[i], ackA[i], clrA[i]);
         for (int i = 0; i < NB; i++) mB[i] <= step(mB[i], 1'b0, reqB[i], ackB[i], clrB[i]);
      end
   end

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : cmp
      logic [5:0] o;
      logic [NA-1:0] eA [6];
      logic [NB-1:0] eB [6];
      if (!rst) begin
         for (int i = 0; i < NA; i++) begin
            o = outs(mA[i], 1'b1);
            for (int k = 0; k < 6; k++) eA[k][i] = o[5-k];
         end
         for (int i = 0; i < NB; i++) begin
            o = outs(mB[i], 1'b0);
            for (int k = 0; k < 6; k++) eB[k][i] = o[5-k];
         end
         check("A.isolate", 8'(isoA),   8'(eA[0]));
         check("A.clk_en",  8'(clkEnA), 8'(eA[1]));
         check("A.cl_rst",  8'(cRstA),  8'(eA[2]));
         check("A.pwr_on",  8'(onA),    8'(eA[3]));
         check("A.busy",    8'(busyA),  8'(eA[4]));
         check("A.err",     8'(errA),   8'(eA[5]));
         check("B.isolate", 8'(isoB),   8'(eB[0]));
         check("B.clk_en",  8'(clkEnB), 8'(eB[1]));
         check("B.cl_rst",  8'(cRstB),  8'(eB[2]));
         check("B.pwr_on",  8'(onB),    8'(eB[3]));
         check("B.busy",    8'(busyB),  8'(eB[4]));
         check("B.err",     8'(errB),   8'(eB[5]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, ".A.iso"},   8'(isoA),   8'h1f);
      check({tag, ".A.clken"}, 8'(clkEnA), 8'h00);
      check({tag, ".A.rst"},   8'(cRstA),  8'h1f);
      check({tag, ".A.on"},    8'(onA),    8'h00);
      check({tag, ".A.busy"},  8'(busyA),  8'h00);
      check({tag, ".A.err"},   8'(errA),   8'h00);
      check({tag, ".B.iso"},   8'(isoB),   8'h00);
      check({tag, ".B.rst"},   8'(cRstB),  8'h03);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("rst0");
      rst = 1'b0;
      tick();
      tick();

      // Power-up cluster 0 on both instances at edge 0.
      reqA[0] = 1'b1;
      reqB[0] = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e >= 1 && e <= 6) check("up.busy", 8'(busyA[0]), 8'd1);
         if (e == 1) check("up.clken@1", 8'(clkEnA[0]), 8'd1);
         if (e == 4) check("up.rst@4", 8'(cRstA[0]), 8'd1);
         if (e == 5) check("up.rst@5", 8'(cRstA[0]), 8'd0);
         if (e == 5) check("upB.on@5", 8'(onB[0]), 8'd0);
         if (e == 6) check("up.iso@6", 8'(isoA[0]), 8'd0);
         if (e == 6) check("up.on@6", 8'(onA[0]), 8'd0);
         if (e == 6) check("upB.on@6", 8'(onB[0]), 8'd1);
         if (e == 7) check("up.on@7", 8'(onA[0]), 8'd1);
         if (e == 7) check("up.others", 8'(clkEnA), 8'h01);
      end

      // Power-down cluster 0; ack rises two edges after isolation.
      reqA[0] = 1'b0;
      reqB[0] = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (e == 1) check("dn.iso@1", 8'(isoA[0]), 8'd1);
         if (e == 3) begin
            check("dn.rst@3", 8'(cRstA[0]), 8'd0);
            ackA[0] = 1'b1;
         end
         if (e == 4) check("dn.rst@4", 8'(cRstA[0]), 8'd1);
         if (e == 7) check("dn.clken@7", 8'(clkEnA[0]), 8'd1);
         if (e == 8) check("dn.clken@8", 8'(clkEnA[0]), 8'd0);
         if (e == 8) check("dn.busy@8", 8'(busyA[0]), 8'd1);
         if (e == 9) check("dn.busy@9", 8'(busyA[0]), 8'd0);
      end
      ackA[0] = 1'b0;

      // Cluster 1: ISO timeout with ack stuck low, then clear.
      reqA[1] = 1'b1;
      repeat (8) tick();
      check("to.on", 8'(onA[1]), 8'd1);
      reqA[1] = 1'b0;
      for (int e = 1; e <= 24; e++) begin
         tick();
         if (e == 1) check("to.iso@1", 8'(isoA[1]), 8'd1);
         if (e == 16) check("to.err@16", 8'(errA[1]), 8'd0);
         if (e == 16) check("to.rst@16", 8'(cRstA[1]), 8'd0);
         if (e == 17) check("to.err@17", 8'(errA[1]), 8'd1);
         if (e == 17) check("to.rst@17", 8'(cRstA[1]), 8'd1);
         if (e == 21) check("to.clken@21", 8'(clkEnA[1]), 8'd0);
         if (e == 22) begin
            check("to.busy@22", 8'(busyA[1]), 8'd0);
            check("to.errheld", 8'(errA[1]), 8'd1);
            clrA[1] = 1'b1;
         end
         if (e == 23) begin
            check("to.clr", 8'(errA[1]), 8'd0);
            clrA[1] = 1'b0;
         end
      end

      // Cluster 2 up normally; cluster 3 up with ack stuck high (de-isolation timeout).
      reqA[2] = 1'b1;
      reqA[3] = 1'b1;
      ackA[3] = 1'b1;
      for (int e = 1; e <= 24; e++) begin
         tick();
         if (e == 7) check("up2.on@7", 8'(onA[2]), 8'd1);
         if (e == 21) check("deiso.on@21", 8'(onA[3]), 8'd0);
         if (e == 21) check("deiso.err@21", 8'(errA[3]), 8'd0);
         if (e == 22) check("deiso.on@22", 8'(onA[3]), 8'd1);
         if (e == 22) check("deiso.err@22", 8'(errA[3]), 8'd1);
      end
      ackA[3] = 1'b0;

      // Cluster 2 down with ack stuck low; clear pulse lands on the timeout edge.
      reqA[2] = 1'b0;
      for (int e = 1; e <= 18; e++) begin
         tick();
         if (e == 16) begin
            check("both.err@16", 8'(errA[2]), 8'd0);
            clrA[2] = 1'b1;
         end
         if (e == 17) begin
            check("both.err@17", 8'(errA[2]), 8'd1);
            clrA[2] = 1'b0;
         end
         if (e == 18) check("both.err@18", 8'(errA[2]), 8'd1);
      end

      // Cluster 4: request dropped mid CLK_UP; up completes, then down.
      reqA[4] = 1'b1;
      for (int e = 1; e <= 15; e++) begin
         tick();
         if (e == 2) reqA[4] = 1'b0;
         if (e == 7) check("tog.on@7", 8'(onA[4]), 8'd1);
         if (e == 8) begin
            check("tog.on@8", 8'(onA[4]), 8'd0);
            check("tog.iso@8", 8'(isoA[4]), 8'd1);
            ackA[4] = 1'b1;
         end
         if (e == 13) check("tog.clken@13", 8'(clkEnA[4]), 8'd0);
         if (e == 13) check("tog.busy@13", 8'(busyA[4]), 8'd1);
         if (e == 14) check("tog.busy@14", 8'(busyA[4]), 8'd0);
      end
      ackA[4] = 1'b0;

      // Async reset in the middle of RST_DN on cluster 0.
      reqA[0] = 1'b1;
      repeat (8) tick();
      ackA[0] = 1'b1;
      reqA[0] = 1'b0;
      tick();
      tick();
      tick();
      check("ar.busy", 8'(busyA[0]), 8'd1);
      check("ar.rst", 8'(cRstA[0]), 8'd1);
      #2;
      rst = 1'b1;
      #1;
      checkResetOutputs("async");
      ackA[0] = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      repeat (12) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
